// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking mask enabled with `define BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  valid_in,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  valid_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WIDTH-1:0]    shreg;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (valid_in) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg     <= '0;
            scratch   <= '0;
            cnt       <= '0;
            bcd_out   <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_in) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    // Top scratch bit is always 0 for legal WIDTH/DIGITS.
                    scratch <= {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
                    shreg   <= shreg << 1;
                    cnt     <= cnt + CW'(1);
                end
                DONE: begin
                    bcd_out   <= scratch;
                    valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;

    // Digit i blanks when it and every higher digit are zero; units never.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (scratch[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank <= '0;
        end else if (state == DONE) begin
            blank <= blank_nxt;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against an arithmetic
// decimal model; expects blanking when BCD_BLANK_EN is defined.
module tb_bin2bcd_seq;

    localparam int W = 16;
    localparam int D = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   bin_in;
    logic           valid_in;
    logic           busy;
    logic [4*D-1:0] bcd_out;
    logic           valid_out;
    logic [D-1:0]   blank;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [4*D-1:0] last_bcd = '0;

    bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .valid_in  (valid_in),
        .busy      (busy),
        .bcd_out   (bcd_out),
        .valid_out (valid_out),
        .blank     (blank)
    );

    always #5 clk = ~clk;

    function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
        logic [4*D-1:0] r;
        int unsigned    x;
        r = '0;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [D-1:0] ref_blank(input int unsigned v);
        logic [D-1:0] r;
        int unsigned  p;
        r = '0;
        p = 1;
`ifdef BCD_BLANK_EN
        for (int i = 1; i < D; i++) begin
            p = p * 10;
            r[i] = (v < p);
        end
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic conv(input int unsigned v);
        int   n;
        logic ok;
        wait_idle();
        bin_in   = W'(v);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        chk("busy_accept", 32'(busy), 32'd1);
        n  = 0;
        ok = 1'b1;
        while (!valid_out && n < 40) begin
            bin_in = W'($urandom);
            step();
            n++;
            if (!valid_out && (bcd_out !== last_bcd || !busy)) ok = 1'b0;
        end
        chk("latency", 32'(n), 32'd17);
        chk("bcd", 32'(bcd_out), 32'(ref_bcd(v)));
        chk("blank", 32'(blank), 32'(ref_blank(v)));
        chk("hold_busy", 32'(ok), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        last_bcd = ref_bcd(v);
        step();
        chk("pulse_width", 32'(valid_out), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        int p1;
        int p2;
        logic [4*D-1:0] got_bcd;

        rst      = 1'b0;
        valid_in = 1'b1;
        bin_in   = 16'd150;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_blank", 32'(blank), 32'd0);
        valid_in = 1'b0;
        rst      = 1'b1;
        step();

        conv(150);
        conv(0);
        conv(65535);
        for (int i = 0; i < 20; i++) conv($urandom_range(0, 65535));

        // Request while busy must be ignored
        wait_idle();
        bin_in   = 16'd1234;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        n        = 0;
        pulses   = 0;
        got_bcd  = '0;
        p1       = -1;
        while (n < 40) begin
            if (n == 4) begin
                bin_in   = 16'd999;
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            step();
            n++;
            if (valid_out) begin
                pulses++;
                got_bcd = bcd_out;
                if (p1 < 0) p1 = n;
            end
        end
        chk("busy_pulses", 32'(pulses), 32'd1);
        chk("busy_latency", 32'(p1), 32'd17);
        chk("busy_bcd", 32'(got_bcd), 32'(ref_bcd(1234)));
        chk("busy_idle", 32'(busy), 32'd0);
        last_bcd = ref_bcd(1234);

        // Asynchronous reset mid-conversion
        bin_in   = 16'd4321;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(valid_out), 32'd0);
        chk("arst_bcd", 32'(bcd_out), 32'd0);
        chk("arst_blank", 32'(blank), 32'd0);
        step();
        step();
        rst    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (valid_out) pulses++;
        end
        chk("arst_no_pulse", 32'(pulses), 32'd0);
        last_bcd = '0;
        conv(77);

        // Back-to-back with valid_in held high
        wait_idle();
        bin_in   = 16'd10;
        valid_in = 1'b1;
        step();
        bin_in = 16'd20;
        n  = 0;
        p1 = -1;
        p2 = -1;
        while (n < 60 && p2 < 0) begin
            step();
            n++;
            if (valid_out) begin
                if (p1 < 0) begin
                    p1 = n;
                    chk("b2b_bcd1", 32'(bcd_out), 32'(ref_bcd(10)));
                end else begin
                    p2 = n;
                    valid_in = 1'b0;
                    chk("b2b_bcd2", 32'(bcd_out), 32'(ref_bcd(20)));
                end
            end
        end
        valid_in = 1'b0;
        chk("b2b_first", 32'(p1), 32'd17);
        chk("b2b_gap", 32'(p2 - p1), 32'd18);
        last_bcd = ref_bcd(20);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
